// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
//   Shared definitions for the EXE->MEM pipeline register.
//
//   DATA_W_DEF      default width of the ALU result and store data
//   REG_ADDR_W_DEF  default width of a register address
//   MAX_DEPTH       largest supported number of register slices
//   exe_mem_slice_t packed layout of one slice at the default widths
//                   (valid, control bits, ALU result, store data, dest)
// ---------------------------------------------------------------------------
package pipe_pkg;

    localparam int DATA_W_DEF     = 32;
    localparam int REG_ADDR_W_DEF = 4;
    localparam int MAX_DEPTH      = 4;

    typedef struct packed {
        logic                      valid;
        logic                      wb_en;
        logic                      mem_r_en;
        logic                      mem_w_en;
        logic [DATA_W_DEF-1:0]     alu_res;
        logic [DATA_W_DEF-1:0]     val_rm;
        logic [REG_ADDR_W_DEF-1:0] dest;
    } exe_mem_slice_t;

endpackage : pipe_pkg

// File: rtl/exe_mem_slice.sv
// ---------------------------------------------------------------------------
// exe_mem_slice
//   One register slice of the EXE->MEM pipeline. Update priority on each
//   rising edge is rst > flush > freeze > load. Control bits are stored
//   already qualified by valid, so an empty slice never carries a write
//   enable. Also produces this slice's contribution to the hazard check.
//
//   Optional feature macro: EXE_MEM_INSTR_TRACE_EN
//     defined   - instr_d is registered alongside the data fields
//     undefined - no instruction register, instr_q is constant 0
//
//   Ports
//     clk, rst            clock, synchronous active-high reset
//     freeze, flush       hold contents / clear contents
//     *_d                 values to load (inputs or previous slice)
//     *_q                 registered slice contents
//     src1, src2, two_src ID-stage source registers for the hazard check
//     match               slice is a pending write to src1 or (used) src2
// ---------------------------------------------------------------------------
module exe_mem_slice
    import pipe_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  freeze,
    input  logic                  flush,
    input  logic                  valid_d,
    input  logic                  wb_en_d,
    input  logic                  mem_r_en_d,
    input  logic                  mem_w_en_d,
    input  logic [DATA_W-1:0]     alu_res_d,
    input  logic [DATA_W-1:0]     val_rm_d,
    input  logic [REG_ADDR_W-1:0] dest_d,
    input  logic [31:0]           instr_d,
    input  logic [REG_ADDR_W-1:0] src1,
    input  logic [REG_ADDR_W-1:0] src2,
    input  logic                  two_src,
    output logic                  valid_q,
    output logic                  wb_en_q,
    output logic                  mem_r_en_q,
    output logic                  mem_w_en_q,
    output logic [DATA_W-1:0]     alu_res_q,
    output logic [DATA_W-1:0]     val_rm_q,
    output logic [REG_ADDR_W-1:0] dest_q,
    output logic [31:0]           instr_q,
    output logic                  match
);

    // Same field order as pipe_pkg::exe_mem_slice_t, sized by this
    // instance's parameters.
    typedef struct packed {
        logic                  valid;
        logic                  wb_en;
        logic                  mem_r_en;
        logic                  mem_w_en;
        logic [DATA_W-1:0]     alu_res;
        logic [DATA_W-1:0]     val_rm;
        logic [REG_ADDR_W-1:0] dest;
    } slice_t;

    slice_t q;

    // NOTE: sequential state uses non-blocking assignment so every slice
    // samples its neighbour's pre-edge value and the chain shifts by one.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            // Reset and flush have the same effect: the slice is emptied
            // and its data cleared, so the priority between them is moot.
            q <= '0;
        end else if (!freeze) begin
            q.valid    <= valid_d;
            q.wb_en    <= wb_en_d    & valid_d;
            q.mem_r_en <= mem_r_en_d & valid_d;
            q.mem_w_en <= mem_w_en_d & valid_d;
            q.alu_res  <= alu_res_d;
            q.val_rm   <= val_rm_d;
            q.dest     <= dest_d;
        end
    end

    assign valid_q    = q.valid;
    assign wb_en_q    = q.wb_en;
    assign mem_r_en_q = q.mem_r_en;
    assign mem_w_en_q = q.mem_w_en;
    assign alu_res_q  = q.alu_res;
    assign val_rm_q   = q.val_rm;
    assign dest_q     = q.dest;

    // wb_en is already qualified by valid; valid is kept in the term so the
    // check does not depend on that invariant holding.
    assign match = q.valid && q.wb_en &&
                   ((q.dest == src1) || (two_src && (q.dest == src2)));

`ifdef EXE_MEM_INSTR_TRACE_EN
    logic [31:0] instr_r;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            instr_r <= '0;
        end else if (!freeze) begin
            instr_r <= instr_d;
        end
    end

    assign instr_q = instr_r;
`else
    // Trace disabled: the instruction word is accepted but not stored.
    logic unused_instr;
    assign unused_instr = ^instr_d;
    assign instr_q      = 32'h0;
`endif

endmodule : exe_mem_slice

// File: rtl/exe_mem_pipe_reg.sv
// ---------------------------------------------------------------------------
// exe_mem_pipe_reg
//   EXE->MEM pipeline register built from DEPTH exe_mem_slice instances
//   (legal DEPTH 1..MAX_DEPTH, latency DEPTH cycles). Supports freeze
//   (stall), flush (squash) and reports whether an ID-stage source matches
//   the destination of any in-flight instruction that will write back.
//
//   Optional feature macro: EXE_MEM_INSTR_TRACE_EN
//     defined   - instruction_in travels with the data; instruction_out is
//                 the last slice's instruction
//     undefined - no instruction registers; instruction_out is 32'h0
//
//   Ports
//     clk, rst             clock, synchronous active-high reset
//     freeze, flush        hold all slices / squash all slices
//     valid_in ... dest_in EXE-stage instruction to capture
//     instruction_in       instruction word, trace only
//     src1_in, src2_in     ID-stage source registers
//     two_src_in           src2_in is used by the ID-stage instruction
//     *_out                contents of the last slice (registered)
//     hazard_out           combinational in-flight destination match
// ---------------------------------------------------------------------------
module exe_mem_pipe_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int REG_ADDR_W = REG_ADDR_W_DEF,
    parameter int DEPTH      = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  freeze,
    input  logic                  flush,
    input  logic                  valid_in,
    input  logic                  wb_en_in,
    input  logic                  mem_r_en_in,
    input  logic                  mem_w_en_in,
    input  logic [DATA_W-1:0]     alu_res_in,
    input  logic [DATA_W-1:0]     val_rm_in,
    input  logic [REG_ADDR_W-1:0] dest_in,
    input  logic [31:0]           instruction_in,
    input  logic [REG_ADDR_W-1:0] src1_in,
    input  logic [REG_ADDR_W-1:0] src2_in,
    input  logic                  two_src_in,
    output logic                  valid_out,
    output logic                  wb_en_out,
    output logic                  mem_r_en_out,
    output logic                  mem_w_en_out,
    output logic [DATA_W-1:0]     alu_result_out,
    output logic [DATA_W-1:0]     val_rm_out,
    output logic [REG_ADDR_W-1:0] dest_out,
    output logic [31:0]           instruction_out,
    output logic                  hazard_out
);

    // Per-slice load values (_d) and registered contents (_q).
    logic [DEPTH-1:0]      valid_d, valid_q;
    logic [DEPTH-1:0]      wb_en_d, wb_en_q;
    logic [DEPTH-1:0]      mem_r_en_d, mem_r_en_q;
    logic [DEPTH-1:0]      mem_w_en_d, mem_w_en_q;
    logic [DATA_W-1:0]     alu_res_d [DEPTH];
    logic [DATA_W-1:0]     alu_res_q [DEPTH];
    logic [DATA_W-1:0]     val_rm_d  [DEPTH];
    logic [DATA_W-1:0]     val_rm_q  [DEPTH];
    logic [REG_ADDR_W-1:0] dest_d    [DEPTH];
    logic [REG_ADDR_W-1:0] dest_q    [DEPTH];
    logic [31:0]           instr_d   [DEPTH];
    logic [31:0]           instr_q   [DEPTH];
    logic [DEPTH-1:0]      match;

    for (genvar k = 0; k < DEPTH; k++) begin : g_slice
        if (k == 0) begin : g_head
            // The head slice loads straight from the EXE stage.
            assign valid_d[k]    = valid_in;
            assign wb_en_d[k]    = wb_en_in;
            assign mem_r_en_d[k] = mem_r_en_in;
            assign mem_w_en_d[k] = mem_w_en_in;
            assign alu_res_d[k]  = alu_res_in;
            assign val_rm_d[k]   = val_rm_in;
            assign dest_d[k]     = dest_in;
            assign instr_d[k]    = instruction_in;
        end else begin : g_tail
            assign valid_d[k]    = valid_q[k-1];
            assign wb_en_d[k]    = wb_en_q[k-1];
            assign mem_r_en_d[k] = mem_r_en_q[k-1];
            assign mem_w_en_d[k] = mem_w_en_q[k-1];
            assign alu_res_d[k]  = alu_res_q[k-1];
            assign val_rm_d[k]   = val_rm_q[k-1];
            assign dest_d[k]     = dest_q[k-1];
            assign instr_d[k]    = instr_q[k-1];
        end

        // NOTE: every slice, not just the output one, is cleared on reset so
        // no stale instruction can surface or raise a hazard afterwards.
        exe_mem_slice #(
            .DATA_W     (DATA_W),
            .REG_ADDR_W (REG_ADDR_W)
        ) u_slice (
            .clk        (clk),
            .rst        (rst),
            .freeze     (freeze),
            .flush      (flush),
            .valid_d    (valid_d[k]),
            .wb_en_d    (wb_en_d[k]),
            .mem_r_en_d (mem_r_en_d[k]),
            .mem_w_en_d (mem_w_en_d[k]),
            .alu_res_d  (alu_res_d[k]),
            .val_rm_d   (val_rm_d[k]),
            .dest_d     (dest_d[k]),
            .instr_d    (instr_d[k]),
            .src1       (src1_in),
            .src2       (src2_in),
            .two_src    (two_src_in),
            .valid_q    (valid_q[k]),
            .wb_en_q    (wb_en_q[k]),
            .mem_r_en_q (mem_r_en_q[k]),
            .mem_w_en_q (mem_w_en_q[k]),
            .alu_res_q  (alu_res_q[k]),
            .val_rm_q   (val_rm_q[k]),
            .dest_q     (dest_q[k]),
            .instr_q    (instr_q[k]),
            .match      (match[k])
        );
    end

    // Outputs come straight from the last slice's flops.
    assign valid_out      = valid_q[DEPTH-1];
    assign wb_en_out      = wb_en_q[DEPTH-1];
    assign mem_r_en_out   = mem_r_en_q[DEPTH-1];
    assign mem_w_en_out   = mem_w_en_q[DEPTH-1];
    assign alu_result_out = alu_res_q[DEPTH-1];
    assign val_rm_out     = val_rm_q[DEPTH-1];
    assign dest_out       = dest_q[DEPTH-1];
    // Without the trace build every slice drives a constant 0 here.
    assign instruction_out = instr_q[DEPTH-1];

    // NOTE: combinational block assigns its output unconditionally, so no
    // latch can be inferred.
    always_comb begin
        hazard_out = |match;
    end

endmodule : exe_mem_pipe_reg

// File: tb/tb_exe_mem_pipe_reg.sv
// ---------------------------------------------------------------------------
// tb_exe_mem_pipe_reg
//   Directed bench for exe_mem_pipe_reg. Two instances share one set of
//   inputs: u2 (DEPTH=2) and u3 (DEPTH=3). Inputs change and outputs are
//   sampled 1 ns after each rising edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_exe_mem_pipe_reg;

    logic        clk = 1'b0;
    logic        rst, freeze, flush;
    logic        valid_in, wb_en_in, mem_r_en_in, mem_w_en_in;
    logic [31:0] alu_res_in, val_rm_in, instruction_in;
    logic [3:0]  dest_in, src1_in, src2_in;
    logic        two_src_in;

    logic        o2_valid, o2_wb, o2_mr, o2_mw, o2_hz;
    logic [31:0] o2_alu, o2_rm, o2_instr;
    logic [3:0]  o2_dest;
    logic        o3_valid, o3_wb, o3_mr, o3_mw, o3_hz;
    logic [31:0] o3_alu, o3_rm, o3_instr;
    logic [3:0]  o3_dest;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    exe_mem_pipe_reg #(.DATA_W(32), .REG_ADDR_W(4), .DEPTH(2)) u2 (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
        .valid_in(valid_in), .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in),
        .mem_w_en_in(mem_w_en_in), .alu_res_in(alu_res_in), .val_rm_in(val_rm_in),
        .dest_in(dest_in), .instruction_in(instruction_in), .src1_in(src1_in),
        .src2_in(src2_in), .two_src_in(two_src_in), .valid_out(o2_valid),
        .wb_en_out(o2_wb), .mem_r_en_out(o2_mr), .mem_w_en_out(o2_mw),
        .alu_result_out(o2_alu), .val_rm_out(o2_rm), .dest_out(o2_dest),
        .instruction_out(o2_instr), .hazard_out(o2_hz)
    );

    exe_mem_pipe_reg #(.DATA_W(32), .REG_ADDR_W(4), .DEPTH(3)) u3 (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
        .valid_in(valid_in), .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in),
        .mem_w_en_in(mem_w_en_in), .alu_res_in(alu_res_in), .val_rm_in(val_rm_in),
        .dest_in(dest_in), .instruction_in(instruction_in), .src1_in(src1_in),
        .src2_in(src2_in), .two_src_in(two_src_in), .valid_out(o3_valid),
        .wb_en_out(o3_wb), .mem_r_en_out(o3_mr), .mem_w_en_out(o3_mw),
        .alu_result_out(o3_alu), .val_rm_out(o3_rm), .dest_out(o3_dest),
        .instruction_out(o3_instr), .hazard_out(o3_hz)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 1'b0; freeze = 1'b0; flush = 1'b0;
        valid_in = 1'b0; wb_en_in = 1'b0; mem_r_en_in = 1'b0; mem_w_en_in = 1'b0;
        alu_res_in = '0; val_rm_in = '0; dest_in = '0; instruction_in = '0;
        src1_in = '0; src2_in = '0; two_src_in = 1'b0;
    endtask

    // Reset with nonzero inputs, then reset in the middle of a transfer.
    task automatic test_reset();
        idle();
        rst = 1'b1; valid_in = 1'b1; wb_en_in = 1'b1; mem_r_en_in = 1'b1;
        mem_w_en_in = 1'b1; alu_res_in = 32'hFFFF_FFFF; val_rm_in = 32'hA5A5_A5A5;
        dest_in = 4'h3; instruction_in = 32'hE081_1002;
        src1_in = 4'h3; src2_in = 4'h3; two_src_in = 1'b1;
        tick(); tick();
        checks++;
        if ({o2_valid, o2_wb, o2_mr, o2_mw} !== 4'b0000) begin
            errors++; $display("FAIL reset_ctrl_d2: got %b want 0000", {o2_valid, o2_wb, o2_mr, o2_mw});
        end
        checks++;
        if ({o2_alu, o2_rm, o2_dest, o2_instr} !== 100'h0) begin
            errors++; $display("FAIL reset_data_d2: got %h/%h/%h/%h want 0", o2_alu, o2_rm, o2_dest, o2_instr);
        end
        checks++;
        if ({o2_hz, o3_hz} !== 2'b00) begin
            errors++; $display("FAIL reset_hazard: got %b want 00", {o2_hz, o3_hz});
        end
        checks++;
        if ({o3_valid, o3_wb, o3_mr, o3_mw} !== 4'b0000) begin
            errors++; $display("FAIL reset_ctrl_d3: got %b want 0000", {o3_valid, o3_wb, o3_mr, o3_mw});
        end
        // Release reset for one edge: the instruction enters slice 0.
        rst = 1'b0;
        tick();
        checks++;
        if (o2_hz !== 1'b1) begin
            errors++; $display("FAIL reset_release_hazard: got %b want 1", o2_hz);
        end
        // Reset again while the instruction is in flight.
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        src1_in = 4'h3;
        #1;
        checks++;
        if ({o2_valid, o2_hz, o3_hz} !== 3'b000) begin
            errors++; $display("FAIL reset_midstream_d2: got %b want 000", {o2_valid, o2_hz, o3_hz});
        end
        tick();
        checks++;
        if (o3_valid !== 1'b0) begin
            errors++; $display("FAIL reset_midstream_d3: got %b want 0", o3_valid);
        end
        idle();
    endtask

    // One instruction: appears after exactly DEPTH edges, then leaves.
    task automatic test_latency();
        idle();
        valid_in = 1'b1; wb_en_in = 1'b1; alu_res_in = 32'hDEAD_BEEF; dest_in = 4'h5;
        tick();
        idle();
        checks++;
        if (o3_valid !== 1'b0) begin
            errors++; $display("FAIL latency_e1: got valid %b want 0", o3_valid);
        end
        tick();
        checks++;
        if ({o2_valid, o2_alu} !== {1'b1, 32'hDEAD_BEEF} || o3_valid !== 1'b0) begin
            errors++; $display("FAIL latency_e2: got d2 %b/%h d3 %b want 1/deadbeef 0", o2_valid, o2_alu, o3_valid);
        end
        tick();
        checks++;
        if ({o3_valid, o3_wb, o3_mr, o3_mw, o3_alu, o3_dest} !== {4'b1100, 32'hDEAD_BEEF, 4'h5}) begin
            errors++; $display("FAIL latency_e3: got %b%b%b%b/%h/%h want 1100/deadbeef/5",
                               o3_valid, o3_wb, o3_mr, o3_mw, o3_alu, o3_dest);
        end
        tick();
        checks++;
        if (o3_valid !== 1'b0) begin
            errors++; $display("FAIL latency_e4: got valid %b want 0", o3_valid);
        end
    endtask

    // Two freeze cycles mid-transfer delay the output by two cycles.
    task automatic test_freeze();
        idle();
        valid_in = 1'b1; mem_r_en_in = 1'b1; alu_res_in = 32'h1234_5678; dest_in = 4'h7;
        tick();
        idle();
        tick();
        freeze = 1'b1;
        valid_in = 1'b1; alu_res_in = 32'hBAD0_BAD0;   // ignored while frozen
        tick();
        checks++;
        if (o3_valid !== 1'b0) begin
            errors++; $display("FAIL freeze_e3: got valid %b want 0", o3_valid);
        end
        tick();
        checks++;
        if (o3_valid !== 1'b0 || {o2_valid, o2_alu} !== {1'b1, 32'h1234_5678}) begin
            errors++; $display("FAIL freeze_e4: got d3 %b d2 %b/%h want 0 1/12345678", o3_valid, o2_valid, o2_alu);
        end
        idle();
        tick();
        checks++;
        if ({o3_valid, o3_mr, o3_alu, o3_dest} !== {2'b11, 32'h1234_5678, 4'h7} || o2_valid !== 1'b0) begin
            errors++; $display("FAIL freeze_e5: got d3 %b%b/%h/%h d2 %b want 11/12345678/7 0",
                               o3_valid, o3_mr, o3_alu, o3_dest, o2_valid);
        end
        tick();
        checks++;
        if (o3_valid !== 1'b0) begin
            errors++; $display("FAIL freeze_no_dup: got valid %b want 0", o3_valid);
        end
    endtask

    // Flush and freeze together: flush wins and the instruction is gone.
    task automatic test_flush_beats_freeze();
        idle();
        valid_in = 1'b1; wb_en_in = 1'b1; mem_w_en_in = 1'b1; dest_in = 4'hA;
        alu_res_in = 32'h0000_0A0A;
        tick();
        idle();
        src1_in = 4'hA;
        #1;
        checks++;
        if (o3_hz !== 1'b1) begin
            errors++; $display("FAIL flush_pre_hazard: got %b want 1", o3_hz);
        end
        flush = 1'b1; freeze = 1'b1;
        tick();
        checks++;
        if ({o2_valid, o2_mw, o2_hz, o3_hz} !== 4'b0000) begin
            errors++; $display("FAIL flush_freeze: got %b want 0000", {o2_valid, o2_mw, o2_hz, o3_hz});
        end
        flush = 1'b0; freeze = 1'b0;
        tick();
        checks++;
        if ({o3_valid, o3_mw} !== 2'b00) begin
            errors++; $display("FAIL flush_gone_e3: got %b want 00", {o3_valid, o3_mw});
        end
        idle();
    endtask

    // Hazard terms, including movement through and out of the slices.
    task automatic test_hazard();
        idle();
        valid_in = 1'b1; wb_en_in = 1'b1; dest_in = 4'h3;
        tick();
        idle();
        freeze = 1'b1;
        src1_in = 4'h3;
        #1;
        checks++;
        if (o3_hz !== 1'b1) begin
            errors++; $display("FAIL hazard_src1: got %b want 1", o3_hz);
        end
        src1_in = 4'h0; src2_in = 4'h3; two_src_in = 1'b0;
        #1;
        checks++;
        if (o3_hz !== 1'b0) begin
            errors++; $display("FAIL hazard_src2_unused: got %b want 0", o3_hz);
        end
        two_src_in = 1'b1;
        #1;
        checks++;
        if (o3_hz !== 1'b1) begin
            errors++; $display("FAIL hazard_src2_used: got %b want 1", o3_hz);
        end
        src1_in = 4'h4; src2_in = 4'h4;
        #1;
        checks++;
        if (o3_hz !== 1'b0) begin
            errors++; $display("FAIL hazard_no_match: got %b want 0", o3_hz);
        end
        freeze = 1'b0; src1_in = 4'h3; src2_in = 4'h0; two_src_in = 1'b0;
        tick();
        tick();
        checks++;
        if ({o3_hz, o2_hz} !== 2'b10) begin
            errors++; $display("FAIL hazard_last_slice: got d3 %b d2 %b want 1 0", o3_hz, o2_hz);
        end
        tick();
        checks++;
        if (o3_hz !== 1'b0) begin
            errors++; $display("FAIL hazard_departed: got %b want 0", o3_hz);
        end
        // Same destination, but no write-back.
        idle();
        valid_in = 1'b1; wb_en_in = 1'b0; mem_r_en_in = 1'b1; dest_in = 4'h3;
        tick();
        idle();
        src1_in = 4'h3;
        #1;
        checks++;
        if (o3_hz !== 1'b0) begin
            errors++; $display("FAIL hazard_no_wb: got %b want 0", o3_hz);
        end
        flush = 1'b1;
        tick();
        idle();
    endtask

    // Control bits presented without valid_in must never be captured.
    task automatic test_invalid_gating();
        idle();
        valid_in = 1'b0; wb_en_in = 1'b1; mem_r_en_in = 1'b1; mem_w_en_in = 1'b1;
        dest_in = 4'h3; alu_res_in = 32'h55;
        tick();
        idle();
        src1_in = 4'h3;
        #1;
        checks++;
        if (o3_hz !== 1'b0) begin
            errors++; $display("FAIL invalid_hazard: got %b want 0", o3_hz);
        end
        tick(); tick();
        checks++;
        if ({o3_valid, o3_wb, o3_mr, o3_mw} !== 4'b0000) begin
            errors++; $display("FAIL invalid_ctrl: got %b want 0000", {o3_valid, o3_wb, o3_mr, o3_mw});
        end
        idle();
    endtask

    // Three consecutive instructions come out in order, one per cycle.
    task automatic test_back_to_back();
        logic [31:0] alu_v [3] = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333};
        logic [31:0] rm_v  [3] = '{32'h0000_0000, 32'hCAFE_F00D, 32'h0BAD_F00D};
        logic [31:0] ins_v [3] = '{32'hE281_1001, 32'hE591_2000, 32'hE584_3000};
        logic [3:0]  dst_v [3] = '{4'h1, 4'h2, 4'h4};
        logic [2:0]  ctl_v [3] = '{3'b100, 3'b011, 3'b001};   // wb, mem_r, mem_w
        logic [31:0] exp_instr;
        idle();
        for (int c = 0; c < 6; c++) begin
            if (c < 3) begin
                valid_in = 1'b1;
                {wb_en_in, mem_r_en_in, mem_w_en_in} = ctl_v[c];
                alu_res_in = alu_v[c]; val_rm_in = rm_v[c];
                dest_in = dst_v[c]; instruction_in = ins_v[c];
            end else begin
                idle();
            end
            tick();
            if (c >= 2 && c < 5) begin
`ifdef EXE_MEM_INSTR_TRACE_EN
                exp_instr = ins_v[c-2];
`else
                exp_instr = 32'h0;
`endif
                checks++;
                if ({o3_valid, o3_wb, o3_mr, o3_mw, o3_alu, o3_rm, o3_dest, o3_instr} !==
                    {1'b1, ctl_v[c-2], alu_v[c-2], rm_v[c-2], dst_v[c-2], exp_instr}) begin
                    errors++;
                    $display("FAIL b2b_out%0d: got %b%b%b%b/%h/%h/%h/%h want 1%b/%h/%h/%h/%h", c - 2,
                             o3_valid, o3_wb, o3_mr, o3_mw, o3_alu, o3_rm, o3_dest, o3_instr,
                             ctl_v[c-2], alu_v[c-2], rm_v[c-2], dst_v[c-2], exp_instr);
                end
            end
        end
        checks++;
        if (o3_valid !== 1'b0) begin
            errors++; $display("FAIL b2b_tail: got valid %b want 0", o3_valid);
        end
    endtask

    initial begin
        idle();
        rst = 1'b1;
        test_reset();
        test_latency();
        test_freeze();
        test_flush_beats_freeze();
        test_hazard();
        test_invalid_gating();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_exe_mem_pipe_reg
